seq_responder: RTL and testbench
================================

SEQ_RESPONDER -- requirements
Module: seq_responder

Interface
REQ-001 The block SHALL have parameter JLEN, default 4, giving the number of J response cycles (legal 1..15).
REQ-002 The block SHALL have parameter BMAX, default 3, giving the maximum B repetitions accepted in the enabling sequence (legal 1..7).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on posedge CLK.
REQ-004 The block SHALL have port RESET, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have ports A, B and C, each an input of 1 bit, carrying the enabling-sequence tokens.
REQ-006 The block SHALL have port X, input, 1 bit, the abort request.
REQ-007 The block SHALL have port J, output, 1 bit, the registered response body.
REQ-008 The block SHALL have port K, output, 1 bit, the registered response terminator.
REQ-009 The block SHALL have port BUSY, output, 1 bit, high while a response is in progress.

Function
REQ-010 The block SHALL sample all inputs on posedge CLK and drive J, K and BUSY directly from flops, with no combinational input-to-output path.
REQ-011 The FSM SHALL have exactly these states: IDLE, GOT_C, GOT_B, RESP_J, RESP_K.
REQ-012 In IDLE: C=1 -> GOT_C; otherwise remain in IDLE.
REQ-013 In GOT_C: B=1 -> GOT_B with bcnt=1; else C=1 -> GOT_C; else -> IDLE.
REQ-014 In GOT_B, priority is A over B over C: A=1 -> RESP_J with jcnt=1; else B=1 and bcnt<BMAX -> bcnt+1; else C=1 -> GOT_C; else -> IDLE.
REQ-015 B=1 in GOT_B with bcnt==BMAX and A=0 SHALL abandon the sequence, going to GOT_C if C=1 and to IDLE otherwise.
REQ-016 Latency: if A completing C ##1 B[*1:BMAX] ##1 A is sampled at edge n, J SHALL be 1 after edges n..n+JLEN-1 and K SHALL be 1 after edge n+JLEN only.
REQ-017 In RESP_J: jcnt<JLEN -> jcnt+1; jcnt==JLEN -> RESP_K.
REQ-018 In RESP_K the block SHALL go to IDLE at the next edge, and J, K SHALL be 0 after that edge.
REQ-019 Responses SHALL be non-overlapping: A, B and C SHALL be ignored in RESP_J and RESP_K, and a new enabling sequence may begin only from IDLE after K.
REQ-020 X=1 sampled in any state SHALL force IDLE, with J=K=BUSY=0 after that edge; X has priority over every other transition.
REQ-021 BUSY SHALL be 1 exactly when J|K is 1.
REQ-022 bcnt SHALL be 3 bits and jcnt SHALL be 4 bits; neither counter SHALL wrap, because both are bounded by BMAX and JLEN.

Reset
REQ-023 RESET=1 SHALL immediately (asynchronously) force IDLE and set J=0, K=0, BUSY=0, bcnt=0 and jcnt=0, including mid-response.
REQ-024 After RESET deasserts, the first edge SHALL evaluate from IDLE, and no partial sequence SHALL be retained.

Configuration
REQ-025 When macro SEQ_RESPONDER_STATS_EN is defined, the block SHALL add output PASS_CNT [7:0], which increments on each entry to RESP_K.
REQ-026 When SEQ_RESPONDER_STATS_EN is defined, the block SHALL add output ABORT_CNT [7:0], which increments when X aborts a non-IDLE state.
REQ-027 PASS_CNT and ABORT_CNT SHALL saturate at 255 and SHALL reset to 0.
REQ-028 When SEQ_RESPONDER_STATS_EN is undefined, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL drive C;B;B;B with no A and check that J and K stay 0 and the state returns to IDLE.
REQ-030 The bench SHALL drive C;B;A with defaults and check J=1 for 4 cycles starting the cycle after A, then K=1 for 1 cycle, with BUSY matching.
REQ-031 The bench SHALL drive C;B;B;B;A and check the same 4J+1K response; with STATS_EN it SHALL check PASS_CNT=1.
REQ-032 The bench SHALL drive C;B;B;B;B;A and check no response, since the 4th B exceeds BMAX=3.
REQ-033 The bench SHALL drive C;B;A, then X during the 3rd J cycle, and check J=0 the next cycle, no K, and ABORT_CNT=1 with STATS_EN.
REQ-034 The bench SHALL assert RESET mid-RESP_J and check J=0 immediately without waiting for an edge, then drive C;B;A after release and check a full 4J+1K response.

Source files
------------

// File: rtl/seq_responder.sv
// Sequence responder: recognises C ##1 B[*1:BMAX] ##1 A and answers with JLEN cycles of J then one K.
// Define SEQ_RESPONDER_STATS_EN to add the saturating PASS_CNT / ABORT_CNT statistics outputs.
module seq_responder #(
  parameter int JLEN = 4,
  parameter int BMAX = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       X,
  output logic       J,
  output logic       K,
  output logic       BUSY
`ifdef SEQ_RESPONDER_STATS_EN
  ,
  output logic [7:0] PASS_CNT,
  output logic [7:0] ABORT_CNT
`endif
);

  localparam logic [2:0] BMAX_V = 3'(BMAX);
  localparam logic [3:0] JLEN_V = 4'(JLEN);

  typedef enum logic [2:0] {
    IDLE,
    GOT_C,
    GOT_B,
    RESP_J,
    RESP_K
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] bcnt;
  logic [2:0] bcnt_n;
  logic [3:0] jcnt;
  logic [3:0] jcnt_n;

  // X overrides everything; inputs A/B/C are ignored once a response has started.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    jcnt_n  = jcnt;
    if (X) begin
      state_n = IDLE;
      bcnt_n  = '0;
      jcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          bcnt_n = '0;
          jcnt_n = '0;
          if (C) state_n = GOT_C;
        end
        GOT_C: begin
          if (B) begin
            state_n = GOT_B;
            bcnt_n  = 3'd1;
          end else if (C) begin
            state_n = GOT_C;
          end else begin
            state_n = IDLE;
          end
        end
        GOT_B: begin
          if (A) begin
            state_n = RESP_J;
            jcnt_n  = 4'd1;
          end else if (B && (bcnt < BMAX_V)) begin
            bcnt_n = bcnt + 3'd1;
          end else if (C) begin
            state_n = GOT_C;
          end else begin
            state_n = IDLE;
          end
        end
        RESP_J: begin
          if (jcnt < JLEN_V) jcnt_n = jcnt + 4'd1;
          else               state_n = RESP_K;
        end
        RESP_K: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear right after the deciding edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      bcnt  <= '0;
      jcnt  <= '0;
      J     <= 1'b0;
      K     <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      jcnt  <= jcnt_n;
      J     <= (state_n == RESP_J);
      K     <= (state_n == RESP_K);
      BUSY  <= (state_n == RESP_J) || (state_n == RESP_K);
    end
  end

`ifdef SEQ_RESPONDER_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PASS_CNT  <= '0;
      ABORT_CNT <= '0;
    end else begin
      if ((state_n == RESP_K) && (state != RESP_K) && (PASS_CNT != 8'hFF))
        PASS_CNT <= PASS_CNT + 8'd1;
      if (X && (state != IDLE) && (ABORT_CNT != 8'hFF))
        ABORT_CNT <= ABORT_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_responder.sv
// Scoreboard bench for seq_responder: stimulus pushes expected {J,K,BUSY}, a monitor pops and compares.
// Define SEQ_RESPONDER_STATS_EN to also exercise PASS_CNT / ABORT_CNT.
module tb_seq_responder;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, X = 1'b0;
  logic J, K, BUSY;
`ifdef SEQ_RESPONDER_STATS_EN
  logic [7:0] PASS_CNT, ABORT_CNT;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } exp_t;

  exp_t expQ[$];

  seq_responder #(.JLEN(4), .BMAX(3)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .A(A),
    .B(B),
    .C(C),
    .X(X),
    .J(J),
    .K(K),
    .BUSY(BUSY)
`ifdef SEQ_RESPONDER_STATS_EN
    ,
    .PASS_CNT(PASS_CNT),
    .ABORT_CNT(ABORT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [2:0] exp);
    checks++;
    if ({J, K, BUSY} !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got J=%b K=%b BUSY=%b, expected J=%b K=%b BUSY=%b",
               name, J, K, BUSY, exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs and record what must be visible after the following rising edge.
  task automatic applyStimulus(input string name, input logic a, input logic b, input logic c,
                               input logic x, input logic ej, input logic ek);
    exp_t e;
    @(negedge CLK);
    A = a; B = b; C = c; X = x;
    e.name = name;
    e.exp  = {ej, ek, ej | ek};
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input string name, input int n);
    for (int i = 0; i < n; i++) applyStimulus(name, 0, 0, 0, 0, 0, 0);
  endtask

  // Remaining three J cycles after the A cycle, then K, then quiet.
  task automatic responseTail(input string name);
    applyStimulus(name, 0, 0, 0, 0, 1, 0);
    applyStimulus(name, 0, 0, 0, 0, 1, 0);
    applyStimulus(name, 0, 0, 0, 0, 1, 0);
    applyStimulus(name, 0, 0, 0, 0, 0, 1);
    applyStimulus(name, 0, 0, 0, 0, 0, 0);
    applyStimulus(name, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulseReset();
    @(negedge CLK);
    A = 0; B = 0; C = 0; X = 0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Monitor: compare one queued expectation just after each rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.name, e.exp);
    end
  end

  initial begin
    #2;
    checkOutput("reset_state", 3'b000);
`ifdef SEQ_RESPONDER_STATS_EN
    checkValue("reset_pass_cnt", PASS_CNT, 8'd0);
    checkValue("reset_abort_cnt", ABORT_CNT, 8'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;

    // C;B;B;B with no A, then a lone A must not trigger (proves return to IDLE)
    applyStimulus("cbbb", 0, 0, 1, 0, 0, 0);
    applyStimulus("cbbb", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbb", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbb", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbb_idle", 0, 0, 0, 0, 0, 0);
    applyStimulus("cbbb_lone_a", 1, 0, 0, 0, 0, 0);
    idleCycles("cbbb_quiet", 3);

    // C;B;A basic response
    pulseReset();
    applyStimulus("cba", 0, 0, 1, 0, 0, 0);
    applyStimulus("cba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cba_a", 1, 0, 0, 0, 1, 0);
    responseTail("cba_resp");

    // C;B;B;B;A at the BMAX boundary
    pulseReset();
    applyStimulus("cbbba", 0, 0, 1, 0, 0, 0);
    applyStimulus("cbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbba_a", 1, 0, 0, 0, 1, 0);
    responseTail("cbbba_resp");
`ifdef SEQ_RESPONDER_STATS_EN
    @(negedge CLK);
    checkValue("pass_cnt", PASS_CNT, 8'd1);
`endif

    // C;B;B;B;B;A: fourth B exceeds BMAX, sequence abandoned
    pulseReset();
    applyStimulus("cbbbba", 0, 0, 1, 0, 0, 0);
    applyStimulus("cbbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbbba", 0, 1, 0, 0, 0, 0);
    applyStimulus("cbbbba_a", 1, 0, 0, 0, 0, 0);
    idleCycles("cbbbba_quiet", 5);

    // Inputs ignored while responding: C;B during RESP_J must not restart anything
    pulseReset();
    applyStimulus("ignore", 0, 0, 1, 0, 0, 0);
    applyStimulus("ignore", 0, 1, 0, 0, 0, 0);
    applyStimulus("ignore_a", 1, 0, 0, 0, 1, 0);
    applyStimulus("ignore_c", 0, 0, 1, 0, 1, 0);
    applyStimulus("ignore_b", 0, 1, 0, 0, 1, 0);
    applyStimulus("ignore_a2", 1, 0, 0, 0, 1, 0);
    applyStimulus("ignore_k", 0, 0, 0, 0, 0, 1);
    idleCycles("ignore_quiet", 3);

    // X during the third J cycle aborts
    pulseReset();
    applyStimulus("abort", 0, 0, 1, 0, 0, 0);
    applyStimulus("abort", 0, 1, 0, 0, 0, 0);
    applyStimulus("abort_a", 1, 0, 0, 0, 1, 0);
    applyStimulus("abort_j2", 0, 0, 0, 0, 1, 0);
    applyStimulus("abort_j3", 0, 0, 0, 0, 1, 0);
    applyStimulus("abort_x", 0, 0, 0, 1, 0, 0);
    idleCycles("abort_no_k", 4);
`ifdef SEQ_RESPONDER_STATS_EN
    @(negedge CLK);
    checkValue("abort_cnt", ABORT_CNT, 8'd1);
    checkValue("abort_pass_cnt", PASS_CNT, 8'd0);
`endif

    // Asynchronous reset in the middle of RESP_J, then a full response afterwards
    pulseReset();
    applyStimulus("rst", 0, 0, 1, 0, 0, 0);
    applyStimulus("rst", 0, 1, 0, 0, 0, 0);
    applyStimulus("rst_a", 1, 0, 0, 0, 1, 0);
    applyStimulus("rst_j2", 0, 0, 0, 0, 1, 0);
    @(negedge CLK);
    A = 0; B = 0; C = 0; X = 0;
    RESET = 1'b1;
    #1;
    checkOutput("async_reset", 3'b000);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    applyStimulus("post_rst", 0, 0, 1, 0, 0, 0);
    applyStimulus("post_rst", 0, 1, 0, 0, 0, 0);
    applyStimulus("post_rst_a", 1, 0, 0, 0, 1, 0);
    responseTail("post_rst_resp");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge CLK);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
